// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset constants, the
// fetch FSM encoding and the {instr, pc} entry carried through the skid buffer.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// imem_req/imem_addr are held until imem_gnt; imem_rvalid returns data in order,
// at least one cycle after the grant.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that catches a response arriving while
// Decode is stalled. clear has priority over push.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  logic         valid_q;
  fetch_entry_t data_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= din;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, keeps at most one imem request in flight,
// and drives the IF/ID register with stall holding and EX redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic [31:0]          Instruction_id,
  output logic [31:0]          PC_id,
  output logic                 valid_id,
  output fetch_state_e         fsm_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q;
  logic         req;
  logic         fire;
  logic         rsp_in_wait;

  logic         skid_push, skid_pop, skid_clear, skid_valid;
  fetch_entry_t skid_din, skid_dout;

  logic [31:0]  instr_q, pc_id_q;
  logic         valid_q;

  logic         unused_bits;
  assign unused_bits = ^redirect_target[1:0];

  // A new request is only issued when nothing useful is still in flight: either
  // idle, or the outstanding response is being consumed by Decode this cycle.
  always_comb begin
    rsp_in_wait = (state_q == ST_WAIT) && imem.imem_rvalid;
    req         = !reset && !redirect && !skid_valid &&
                  ((state_q == ST_IDLE) || (rsp_in_wait && !stall));
    fire        = req && imem.imem_gnt;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d = align_word(redirect_target);
      unique case (state_q)
        ST_WAIT, ST_DROP: state_d = imem.imem_rvalid ? ST_IDLE : ST_DROP;
        default:          state_d = ST_IDLE;
      endcase
    end else if (fire) begin
      pc_d    = pc_q + 32'd4;
      state_d = ST_WAIT;
    end else if ((state_q != ST_IDLE) && imem.imem_rvalid) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fire) req_pc_q <= pc_q;
    end
  end

  always_comb begin
    skid_push  = rsp_in_wait && stall && !redirect;
    skid_pop   = skid_valid && !stall && !redirect;
    skid_clear = redirect;
    skid_din   = '{instr: imem.imem_rdata, pc: req_pc_q};
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .clear (skid_clear),
    .din   (skid_din),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

  // Redirect overrides stall; a buffered word is older than any live response.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_id_q <= '0;
    end else if (redirect) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!stall) begin
      if (skid_valid) begin
        valid_q <= 1'b1;
        instr_q <= skid_dout.instr;
        pc_id_q <= skid_dout.pc;
      end else if (rsp_in_wait) begin
        valid_q <= 1'b1;
        instr_q <= imem.imem_rdata;
        pc_id_q <= req_pc_q;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign Instruction_id = instr_q;
  assign PC_id          = pc_id_q;
  assign valid_id       = valid_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a single-outstanding imem model whose
// latency and grant are steered cycle by cycle from the main sequence.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic [31:0]  instruction_id;
  logic [31:0]  pc_id;
  logic         valid_id;
  fetch_state_e fsm_state;

  fetch_stage_if imem_bus();

  int checks   = 0;
  int failures = 0;

  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem            (imem_bus.master),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .Instruction_id  (instruction_id),
    .PC_id           (pc_id),
    .valid_id        (valid_id),
    .fsm_state       (fsm_state)
  );

  // Memory: grant observed mid-cycle, data returned lat cycles later.
  initial begin
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    pend  = 1'b0;
    cnt   = 0;
    paddr = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_bus.imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = paddr ^ 32'hA5A5_0000;
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      @(negedge clk);
      if (imem_bus.imem_req && imem_bus.imem_gnt) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_bus.imem_addr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, valid_id}, {31'b0, v});
    chk({tag, ".instr"}, instruction_id, ins);
    chk({tag, ".pc"}, pc_id, pc);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] addr);
    chk({tag, ".req"}, {31'b0, imem_bus.imem_req}, {31'b0, r});
    if (r) chk({tag, ".addr"}, imem_bus.imem_addr, addr);
  endtask

  task automatic chk_st(input string tag, input fetch_state_e s);
    chk({tag, ".state"}, {30'b0, fsm_state}, {30'b0, s});
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    imem_bus.imem_gnt = 1'b1;

    repeat (3) cyc();
    @(negedge clk);
    chk_id("reset", 1'b0, 32'h13, 32'h0);
    chk_req("reset", 1'b0, 32'h0);
    chk_st("reset", ST_IDLE);

    // Streaming at one instruction per cycle
    cyc(); reset = 1'b0; @(negedge clk);
    chk_req("c0", 1'b1, 32'h0);
    cyc(); @(negedge clk);
    chk_req("c1", 1'b1, 32'h4);
    chk("c1.valid", {31'b0, valid_id}, 32'h0);
    cyc(); @(negedge clk);
    chk_id("c2", 1'b1, 32'hA5A5_0000, 32'h0);
    chk_req("c2", 1'b1, 32'h8);

    // Stall while the response for 0x8 arrives
    cyc(); stall = 1'b1; @(negedge clk);
    chk_id("c3", 1'b1, 32'hA5A5_0004, 32'h4);
    chk_req("c3", 1'b0, 32'h0);
    cyc(); @(negedge clk);
    chk_id("c4", 1'b1, 32'hA5A5_0004, 32'h4);
    chk_req("c4", 1'b0, 32'h0);
    cyc(); @(negedge clk);
    chk_id("c5", 1'b1, 32'hA5A5_0004, 32'h4);
    chk_req("c5", 1'b0, 32'h0);
    cyc(); stall = 1'b0; @(negedge clk);
    chk_req("c6", 1'b0, 32'h0);
    chk("c6.pc", pc_id, 32'h4);
    cyc(); @(negedge clk);
    chk_id("c7", 1'b1, 32'hA5A5_0008, 32'h8);
    chk_req("c7", 1'b1, 32'hC);
    cyc(); @(negedge clk);
    chk_id("c8", 1'b0, 32'h13, 32'h8);
    chk_req("c8", 1'b1, 32'h10);
    cyc(); lat = 3; @(negedge clk);
    chk_id("c9", 1'b1, 32'hA5A5_000C, 32'hC);
    chk_req("c9", 1'b1, 32'h14);

    // Redirect with a slow response pending
    cyc(); redirect = 1'b1; redirect_target = 32'h100; @(negedge clk);
    chk_req("c10", 1'b0, 32'h0);
    chk_id("c10", 1'b1, 32'hA5A5_0010, 32'h10);
    cyc(); redirect = 1'b0; @(negedge clk);
    chk_st("c11", ST_DROP);
    chk_req("c11", 1'b0, 32'h0);
    chk_id("c11", 1'b0, 32'h13, 32'h10);
    cyc(); @(negedge clk);
    chk_st("c12", ST_DROP);
    chk_req("c12", 1'b0, 32'h0);
    cyc(); lat = 1; @(negedge clk);
    chk_st("c13", ST_IDLE);
    chk_req("c13", 1'b1, 32'h100);
    chk("c13.valid", {31'b0, valid_id}, 32'h0);
    cyc(); @(negedge clk);
    chk_req("c14", 1'b1, 32'h104);
    chk("c14.valid", {31'b0, valid_id}, 32'h0);

    // Redirect and stall together, unaligned target
    cyc(); redirect = 1'b1; stall = 1'b1; redirect_target = 32'h203; @(negedge clk);
    chk_id("c15", 1'b1, 32'hA5A5_0100, 32'h100);
    chk_req("c15", 1'b0, 32'h0);
    cyc(); redirect = 1'b0; stall = 1'b0; @(negedge clk);
    chk_id("c16", 1'b0, 32'h13, 32'h100);
    chk_req("c16", 1'b1, 32'h200);
    chk_st("c16", ST_IDLE);
    cyc(); lat = 4; @(negedge clk);
    chk_req("c17", 1'b1, 32'h204);
    cyc(); @(negedge clk);
    chk_id("c18", 1'b1, 32'hA5A5_0200, 32'h200);
    chk_req("c18", 1'b0, 32'h0);
    chk_st("c18", ST_WAIT);

    // Reset while waiting; stale response lands just after release
    cyc(); reset = 1'b1; @(negedge clk);
    chk_req("c19", 1'b0, 32'h0);
    cyc(); @(negedge clk);
    chk_id("c20", 1'b0, 32'h13, 32'h0);
    chk_st("c20", ST_IDLE);

    // Grant withheld for four cycles
    cyc(); reset = 1'b0; imem_bus.imem_gnt = 1'b0; lat = 1; @(negedge clk);
    chk("c21.rvalid", {31'b0, imem_bus.imem_rvalid}, 32'h1);
    chk_req("c21", 1'b1, 32'h0);
    cyc(); @(negedge clk);
    chk_id("c22", 1'b0, 32'h13, 32'h0);
    chk_req("c22", 1'b1, 32'h0);
    chk_st("c22", ST_IDLE);
    cyc(); @(negedge clk);
    chk_req("c23", 1'b1, 32'h0);
    cyc(); @(negedge clk);
    chk_req("c24", 1'b1, 32'h0);
    chk_id("c24", 1'b0, 32'h13, 32'h0);
    cyc(); imem_bus.imem_gnt = 1'b1; @(negedge clk);
    chk_req("c25", 1'b1, 32'h0);
    cyc(); @(negedge clk);
    chk_req("c26", 1'b1, 32'h4);
    chk("c26.valid", {31'b0, valid_id}, 32'h0);
    cyc(); @(negedge clk);
    chk_id("c27", 1'b1, 32'hA5A5_0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
